// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Schedules bytes from two sources onto one byte transmitter. The CPU side
// writes into a small FIFO. The debug side presents a single byte with a
// req/ack handshake. When both sources have a byte waiting, they take turns.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   cpu_wr_en/_data    one-cycle byte write into the FIFO
//   cpu_clr_ovf        clears the sticky cpu_overflow flag
//   cpu_full/_level    FIFO full flag and occupancy
//   cpu_overflow       sticky: a write arrived while full and was dropped
//   dbg_req/_data      level request with its byte; dbg_ack pulses on launch
//   tx_en/tx_data      one-cycle start pulse and byte to the transmitter
//   tx_busy            transmitter busy (rises the cycle after tx_en)
//   idle               nothing queued, nothing pending, transmitter quiet
//
// state      | meaning
// IDLE       | free to grant when tx_busy is low
// WAIT_START | byte launched, waiting for tx_busy to rise
// WAIT_DONE  | transmitter running, waiting for tx_busy to fall
module uart_tx_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cpu_wr_en,
    input  logic [7:0]                   cpu_wr_data,
    input  logic                         cpu_clr_ovf,
    output logic                         cpu_full,
    output logic [$clog2(FIFO_DEPTH):0]  cpu_level,
    output logic                         cpu_overflow,
    input  logic                         dbg_req,
    input  logic [7:0]                   dbg_data,
    output logic                         dbg_ack,
    output logic                         tx_en,
    output logic [7:0]                   tx_data,
    input  logic                         tx_busy,
    output logic                         idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            tx_en_q, tx_en_d;
    logic            dbg_ack_q, dbg_ack_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            last_dbg_q, last_dbg_d;   // 1: debug had the last grant
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic full, cpu_pend, grant_ok, pick_dbg, grant_cpu, grant_dbg;
    logic push, pop, drop;

    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        cpu_pend  = (count_q != '0);
        grant_ok  = (state_q == IDLE) && !tx_busy;
        // Debug wins only if the CPU has nothing queued, or if the CPU had the last grant.
        pick_dbg  = dbg_req && (!cpu_pend || !last_dbg_q);
        grant_cpu = grant_ok && cpu_pend && !pick_dbg;
        grant_dbg = grant_ok && pick_dbg;
        pop       = grant_cpu;
        // A write to a full FIFO still fits if the head leaves in the same cycle.
        push      = cpu_wr_en && (!full || pop);
        drop      = cpu_wr_en && !push;

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (cpu_clr_ovf) begin
            ovf_d = 1'b0;
        end

        state_d    = state_q;
        tx_en_d    = 1'b0;
        dbg_ack_d  = 1'b0;
        tx_data_d  = tx_data_q;
        last_dbg_d = last_dbg_q;
        case (state_q)
            IDLE: begin
                if (grant_cpu) begin
                    tx_en_d    = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    last_dbg_d = 1'b0;
                    state_d    = WAIT_START;
                end else if (grant_dbg) begin
                    tx_en_d    = 1'b1;
                    dbg_ack_d  = 1'b1;
                    tx_data_d  = dbg_data;
                    last_dbg_d = 1'b1;
                    state_d    = WAIT_START;
                end
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            dbg_ack_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            last_dbg_q <= 1'b1;   // CPU wins the first tie after reset
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_en_q    <= tx_en_d;
            dbg_ack_q  <= dbg_ack_d;
            tx_data_q  <= tx_data_d;
            last_dbg_q <= last_dbg_d;
        end
    end

    // Storage needs no reset: the pointers and the count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cpu_wr_data;
        end
    end

    assign cpu_full     = full;
    assign cpu_level    = count_q;
    assign cpu_overflow = ovf_q;
    assign tx_en        = tx_en_q;
    assign dbg_ack      = dbg_ack_q;
    assign tx_data      = tx_data_q;
    assign idle         = !cpu_pend && !dbg_req && (state_q == IDLE) && !tx_busy;

endmodule
